fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, 2, output skid-buffer entries (fixed 2; other values unsupported).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_addr  output  32  word-aligned instruction-memory read address.
REQ-006 imem_req  output  1  read strobe; memory returns imem_rdata exactly 1 cycle after a cycle with imem_req=1.
REQ-007 imem_rdata  input  32  instruction read data.
REQ-008 instr  output  32  instruction to decode; bits 31:26 drive the opcode-to-control decoder.
REQ-009 instr_pc4  output  32  PC+4 of instr.
REQ-010 instr_valid  output  1  instr/instr_pc4 valid.
REQ-011 instr_ready  input  1  decode accepts; transfer when instr_valid & instr_ready.
REQ-012 jump  input  1  decoder jump control.
REQ-013 branch  input  1  decoder branch control.
REQ-014 alu_zero  input  1  ALU zero flag for the branch.
REQ-015 redir_pc4  input  32  PC+4 of the jump/branch instruction.
REQ-016 imm16  input  16  branch offset in words.
REQ-017 target26  input  26  jump target field.

Function
REQ-018 Taken = jump | (branch & alu_zero); taken is sampled every cycle regardless of instr_valid.
REQ-019 Branch target = redir_pc4 + (sign_extend(imm16) << 2), 32-bit wrap-around.
REQ-020 Jump target = {redir_pc4[31:28], target26, 2'b00}; jump has priority if jump and branch both high.
REQ-021 FSM states: BOOT, RUN, FULL.
REQ-022 BOOT: entered on reset; next cycle issues imem_req at RESET_PC and goes to RUN.
REQ-023 RUN: imem_req=1 when buffer occupancy plus in-flight reads < 2; pc advances by 4 per issued request.
REQ-024 RUN -> FULL when 2 entries held and no transfer; FULL: imem_req=0; FULL -> RUN on the first transfer cycle.
REQ-025 Returned data is written to the buffer 1 cycle after its request; instr shows the oldest entry; FIFO order preserved.
REQ-026 Steady-state throughput with instr_ready=1: one instruction per cycle; first instr_valid 2 cycles after rst deasserts.
REQ-027 On taken: buffer and any in-flight read are discarded; the same cycle imem_addr = target with imem_req=1; pc = target+4 next; instr_valid=0 the next cycle; first redirected instr valid 2 cycles after taken.
REQ-028 Taken while in FULL: flush, go to RUN, issue target the same cycle.
REQ-029 Simultaneous transfer and taken: the transfer completes; all else is flushed.
REQ-030 instr/instr_pc4 stay stable while instr_valid & !instr_ready.
REQ-031 PC wrap at 32'hFFFF_FFFC -> 32'h0000_0000, no error.

Reset
REQ-032 On rst: state=BOOT, pc=RESET_PC, buffer empty, in-flight cleared, instr_valid=0, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc4=0.
REQ-033 rst asserted mid-operation overrides taken and transfer that cycle; the returning read is discarded.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN: when defined, adds outputs fetch_cnt[31:0] (transfers) and flush_cnt[31:0] (taken events). Both wrap, both reset to 0.
REQ-035 Without FETCH_PERF_CNT_EN: the ports and counters are absent, and all other behaviour is identical.

Structure
REQ-036 Shared package fetch_pkg holds the state enum (BOOT/RUN/FULL), RESET_PC default, and the opcode constants R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, J=6'b000010.
REQ-037 One sub-module fetch_skid_buf (2-entry FIFO with flush, 64-bit entries {instr, pc4}); next-PC logic stays in fetch_unit.

Verification
REQ-038 Reset release, ROM addr/4, instr_ready=1 -> imem_addr 0,4,8,...; instr_valid at cycle 2; instr_pc4 = 4,8,12 back-to-back.
REQ-039 instr_ready=0 for 5 cycles -> FULL, imem_req=0, instr held; ready=1 -> resumes without loss or duplication.
REQ-040 branch=1, alu_zero=1, redir_pc4=0x10, imm16=0xFFFE -> next imem_addr 0x08; the 2 prior fetches are discarded.
REQ-041 jump=1, branch=1, redir_pc4=0xF000_0004, target26=0x0000100 -> imem_addr 0xF000_0400.
REQ-042 Taken while FULL and instr_ready=1 in the same cycle -> the head is transferred once; the next valid instr is from the target.
REQ-043 With FETCH_PERF_CNT_EN: 10 transfers and 2 taken events -> fetch_cnt=10, flush_cnt=2; rst -> both 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, reset PC default, opcode
// constants and next-PC target helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FULL
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                                input logic [25:0] tgt);
        return {pc4_hi, tgt, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output FIFO of {instr, pc4} with synchronous flush.
module fetch_skid_buf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] wdata,
    input  logic        pop,
    output logic [63:0] rdata,
    output logic [1:0]  count
);

    logic [63:0] mem [DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;

    // Storage, pointers and occupancy; flush empties the FIFO and ignores any push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, jump/branch redirect and a
// 2-entry skid buffer toward decode.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [31:0] redir_pc4,
    input  logic [15:0] imm16,
    input  logic [25:0] target26
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc4;
    logic        taken;
    logic [31:0] target;
    logic        xfer;
    logic [1:0]  count;
    logic [2:0]  occ;
    logic [63:0] head;

    assign taken       = jump | (branch & alu_zero);
    assign target      = jump ? jump_target(redir_pc4[31:28], target26)
                              : branch_target(redir_pc4, imm16);
    assign instr_valid = (count != 2'd0);
    assign xfer        = instr_valid & instr_ready;
    // Occupancy counts the entry leaving this cycle as already gone so that
    // a steady ready stream sustains one fetch per cycle.
    assign occ         = {1'b0, count} - {2'b0, xfer} + {2'b0, inflight};
    assign instr       = head[63:32];
    assign instr_pc4   = head[31:0];

    // Next-state and memory request; reset masks everything, redirect beats state.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (taken) begin
            imem_req  = 1'b1;
            imem_addr = target;
            state_nxt = RUN;
        end else begin
            case (state)
                BOOT: begin
                    imem_req  = 1'b1;
                    state_nxt = RUN;
                end
                RUN: begin
                    imem_req = (occ < 3'd2);
                    if (count == 2'd2 && !xfer) begin
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // State, PC and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc4 <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_req;
            if (imem_req) begin
                pc           <= imem_addr + 32'd4;
                inflight_pc4 <= imem_addr + 32'd4;
            end
        end
    end

    fetch_skid_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (taken),
        .push  (inflight),
        .wdata ({imem_rdata, inflight_pc4}),
        .pop   (xfer),
        .rdata (head),
        .count (count)
    );

`ifdef FETCH_PERF_CNT_EN
    // Transfer and redirect event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (xfer) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a ROM model and an expected-stream
// scoreboard; build with or without FETCH_PERF_CNT_EN.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    localparam logic [5:0] OPS [5] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic        branch;
    logic        alu_zero;
    logic [31:0] redir_pc4;
    logic [15:0] imm16;
    logic [25:0] target26;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int   tests = 0;
    int   fails = 0;
    int   exp_fetch = 0;
    int   exp_flush = 0;
    exp_t sb[$];

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc4   (instr_pc4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .redir_pc4   (redir_pc4),
        .imm16       (imm16),
        .target26    (target26)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % 32'd5);
        return {OPS[idx], a[27:2]};
    endfunction

    // One-cycle-latency ROM; garbage when no request was made.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? rom_word(imem_addr) : 32'hDEAD_BEEF;
    end

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            exp_fetch++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL sb_extra: got pc4 %h, required no transfer", instr_pc4);
            end else begin
                exp_t e;
                e = sb.pop_front();
                assert (instr_pc4 === e.pc4 && instr === e.instr) else begin
                    fails++;
                    $error("FAIL sb_xfer: got %h/%h, required %h/%h",
                           instr, instr_pc4, e.instr, e.pc4);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start);
        logic [31:0] a;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            a = start + 32'(4 * i);
            sb.push_back({rom_word(a), a + 32'd4});
        end
    endtask

    task automatic clear_redir();
        jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        redir_pc4 = '0; imm16 = '0; target26 = '0;
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b1;
        clear_redir();
        cyc(); cyc();
        jump = 1'b1; target26 = 26'h40;
        settle();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", instr_pc4, 32'h0);
        cyc(); clear_redir();
`ifdef FETCH_PERF_CNT_EN
        settle();
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        // Release and stream sequentially.
        cyc(); rst = 1'b0; push_stream(32'h0); settle();
        chk("c0_req", {31'b0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); settle();
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); settle();
        chk("c2_valid", {31'b0, instr_valid}, 32'd1);
        chk("c2_pc4", instr_pc4, 32'h4);
        chk("c2_addr", imem_addr, 32'h8);
        for (int k = 3; k < 10; k++) begin
            cyc(); settle();
            chk("seq_addr", imem_addr, 32'(4 * k));
            chk("seq_valid", {31'b0, instr_valid}, 32'd1);
        end
        // Stall five cycles: no requests, head held at pc4 36.
        for (int j = 0; j < 5; j++) begin
            cyc(); instr_ready = 1'b0; settle();
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc4", instr_pc4, 32'd36);
            chk("stall_instr", instr, rom_word(32'd32));
        end
        cyc(); instr_ready = 1'b1;
        for (int j = 0; j < 6; j++) cyc();
        // Taken branch backward: 0x10 + (-2 << 2) = 0x08.
        branch = 1'b1; alu_zero = 1'b1; redir_pc4 = 32'h10; imm16 = 16'hFFFE;
        exp_flush++; settle();
        chk("br_req", {31'b0, imem_req}, 32'd1);
        chk("br_addr", imem_addr, 32'h8);
        cyc(); clear_redir(); push_stream(32'h8); settle();
        chk("br_bubble", {31'b0, instr_valid}, 32'd0);
        chk("br_addr1", imem_addr, 32'hC);
        cyc(); branch = 1'b1; redir_pc4 = 32'h10; imm16 = 16'hFFFE; settle();
        chk("br_first_pc4", instr_pc4, 32'hC);
        chk("br_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("nt_addr", imem_addr, 32'h10);
        cyc(); clear_redir();
        cyc(); cyc();
        // Jump has priority over a simultaneously taken branch.
        cyc(); jump = 1'b1; branch = 1'b1; alu_zero = 1'b1;
        redir_pc4 = 32'hF000_0004; target26 = 26'h0000100; imm16 = 16'h0004;
        exp_flush++; settle();
        chk("jmp_addr", imem_addr, 32'hF000_0400);
        cyc(); clear_redir(); push_stream(32'hF000_0400); settle();
        chk("jmp_bubble", {31'b0, instr_valid}, 32'd0);
        cyc(); settle();
        chk("jmp_first_pc4", instr_pc4, 32'hF000_0404);
        cyc(); cyc(); cyc();
        // Fill the buffer, then redirect in the same cycle decode accepts.
        instr_ready = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        instr_ready = 1'b1; jump = 1'b1; target26 = 26'h80; exp_flush++; settle();
        chk("full_req", {31'b0, imem_req}, 32'd1);
        chk("full_addr", imem_addr, 32'h200);
        cyc(); clear_redir(); push_stream(32'h200); settle();
        chk("full_bubble", {31'b0, instr_valid}, 32'd0);
        cyc(); settle();
        chk("full_first_pc4", instr_pc4, 32'h204);
        cyc(); cyc(); cyc();
        // PC wrap past 0xFFFF_FFFC.
        jump = 1'b1; redir_pc4 = 32'hF000_0000; target26 = 26'h3FF_FFFC; exp_flush++; settle();
        chk("wrap_tgt", imem_addr, 32'hFFFF_FFF0);
        cyc(); clear_redir(); push_stream(32'hFFFF_FFF0);
        for (int k = 1; k < 6; k++) begin
            settle();
            chk("wrap_addr", imem_addr, 32'hFFFF_FFF0 + 32'(4 * k));
            cyc();
        end
        cyc(); cyc();
        // Reset mid-stream overrides a redirect and a transfer.
        rst = 1'b1; jump = 1'b1; target26 = 26'h40; settle();
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        cyc(); clear_redir(); sb.delete(); exp_fetch = 0; exp_flush = 0; settle();
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_pc4", instr_pc4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("mrst_fetch_cnt", fetch_cnt, 32'd0);
        chk("mrst_flush_cnt", flush_cnt, 32'd0);
`endif
        cyc(); rst = 1'b0; push_stream(32'h0); settle();
        chk("mrst_boot_addr", imem_addr, 32'h0);
        chk("mrst_boot_req", {31'b0, imem_req}, 32'd1);
        cyc(); cyc(); settle();
        chk("mrst_first_pc4", instr_pc4, 32'h4);
        // Two redirects, then stop after exactly ten transfers.
        cyc(); jump = 1'b1; target26 = 26'h100; exp_flush++;
        cyc(); clear_redir(); push_stream(32'h400);
        cyc(); cyc(); jump = 1'b1; target26 = 26'h300; exp_flush++;
        cyc(); clear_redir(); push_stream(32'hC00);
        for (int n = 0; n < 40 && exp_fetch < 10; n++) begin
            @(negedge clk); #1;
        end
        instr_ready = 1'b0;
        chk("ten_transfers", 32'(exp_fetch), 32'd10);
        cyc(); settle();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'd10);
        chk("flush_cnt", flush_cnt, 32'(exp_flush));
        chk("flush_cnt_two", 32'(exp_flush), 32'd2);
        rst = 1'b1;
        cyc(); rst = 1'b0; settle();
        chk("end_fetch_cnt", fetch_cnt, 32'd0);
        chk("end_flush_cnt", flush_cnt, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
